// File: rtl/morse_keyer.sv
// rtl/morse_keyer.sv - symbol FIFO plus unit-timed Morse key engine; optional sidetone via MORSE_KEYER_SIDETONE_EN
module morse_keyer #(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int FIFO_DEPTH  = 4,
    parameter int TONE_HALF   = 25_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sym,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       signal,
    output logic       busy,
    output logic       err
`ifdef MORSE_KEYER_SIDETONE_EN
    ,
    output logic       tone
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE
    } state_t;

    logic [2:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, accept, push, pop;
    logic [2:0]  head, mark_units, space_units;

    state_t      state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]  units_q, units_d;
    logic [2:0]  space_q, space_d;
    logic        signal_q, signal_d;
    logic        err_q;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign sym_ready = !full;
    assign accept    = sym_valid && sym_ready;
    assign push      = accept && (sym <= 3'd4);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    assign signal = signal_q;
    assign err    = err_q;
    assign busy   = (state_q != ST_IDLE) || !empty;

    always_comb begin
        mark_units  = 3'd0;
        space_units = 3'd0;
        case (head)
            3'd1:    begin mark_units = 3'd1; space_units = 3'd1; end
            3'd2:    begin mark_units = 3'd3; space_units = 3'd1; end
            3'd3:    space_units = 3'd2;
            3'd4:    space_units = 3'd6;
            default: ;
        endcase
    end

    // Each timed state counts whole units; the last cycle of the last unit selects the exit.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        units_d = units_q;
        space_d = space_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cyc_d = '0;
                    if (mark_units != 3'd0) begin
                        state_d = ST_MARK;
                        units_d = mark_units;
                        space_d = space_units;
                    end else if (space_units != 3'd0) begin
                        state_d = ST_SPACE;
                        units_d = space_units;
                    end
                end
            end
            ST_MARK: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (units_q == 3'd1) begin
                        state_d = ST_SPACE;
                        units_d = space_q;
                    end else begin
                        units_d = units_q - 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_SPACE: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (units_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        units_d = units_q - 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        signal_d = (state_d == ST_MARK);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
            cyc_q    <= '0;
            units_q  <= 3'd0;
            space_q  <= 3'd0;
            signal_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            units_q  <= units_d;
            space_q  <= space_d;
            signal_q <= signal_d;
            err_q    <= accept && (sym > 3'd4);
        end
    end

`ifdef MORSE_KEYER_SIDETONE_EN
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);

    logic [TW-1:0] tcnt_q;
    logic          tone_q;

    assign tone = tone_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            tone_q <= 1'b0;
        end else if (!signal_q) begin
            tcnt_q <= '0;
            tone_q <= 1'b0;
        end else if (tcnt_q == TONE_LAST) begin
            tcnt_q <= '0;
            tone_q <= !tone_q;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// tb/tb_morse_keyer.sv - directed checks of morse_keyer with UNIT_CYCLES=4, FIFO_DEPTH=4, TONE_HALF=2
module tb_morse_keyer;

    logic       clk;
    logic       rst_n;
    logic [2:0] sym;
    logic       sym_valid;
    logic       sym_ready;
    logic       signal;
    logic       busy;
    logic       err;
`ifdef MORSE_KEYER_SIDETONE_EN
    logic       tone;
`endif

    int passed;
    int total;
    int highs;

    morse_keyer #(
        .UNIT_CYCLES(4),
        .FIFO_DEPTH (4),
        .TONE_HALF  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sym      (sym),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .signal   (signal),
        .busy     (busy),
        .err      (err)
`ifdef MORSE_KEYER_SIDETONE_EN
        ,
        .tone     (tone)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        sym       = 3'd0;
        sym_valid = 1'b0;
        #2;
        chk("rst_signal", signal, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready", sym_ready, 1'b1);
`ifdef MORSE_KEYER_SIDETONE_EN
        chk("rst_tone", tone, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Single DIT: high after edges 1-4, low 5-8, idle from 9
        sym = 3'd1;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("dit_e0_signal", signal, 1'b0);
        chk("dit_e0_busy", busy, 1'b1);
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk($sformatf("dit_e%0d_signal", e), signal, (e >= 1 && e <= 4));
            chk($sformatf("dit_e%0d_busy", e), busy, (e < 9));
        end

        // DAH then GAP: high 1-12, low 13-16, idle 17, gap 18-25, idle 26
        sym = 3'd2;
        sym_valid = 1'b1;
        tick();
        sym = 3'd3;
        tick();
        sym_valid = 1'b0;
        chk("dahgap_e1_signal", signal, 1'b1);
        for (int e = 2; e <= 28; e++) begin
            tick();
            chk($sformatf("dahgap_e%0d_signal", e), signal, (e <= 12));
            chk($sformatf("dahgap_e%0d_busy", e), busy, (e < 26));
        end

        // WAIT consumes one cycle and produces nothing
        sym = 3'd0;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("wait_e0_busy", busy, 1'b1);
        tick();
        chk("wait_e1_busy", busy, 1'b0);
        chk("wait_e1_signal", signal, 1'b0);

        // Six DITs: FIFO fills after edge 4, frees at the pop on edge 10
        highs = 0;
        sym = 3'd1;
        sym_valid = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            chk($sformatf("six_ready_pre_e%0d", e), sym_ready, 1'b1);
            tick();
            if (signal) highs++;
        end
        chk("six_ready_e4", sym_ready, 1'b0);
        for (int e = 5; e <= 10; e++) begin
            tick();
            if (signal) highs++;
            chk($sformatf("six_ready_e%0d", e), sym_ready, (e == 10));
        end
        tick();
        if (signal) highs++;
        sym_valid = 1'b0;
        chk("six_ready_e11", sym_ready, 1'b0);
        for (int i = 0; i < 200 && busy; i++) begin
            tick();
            if (signal) highs++;
        end
        chk("six_drained", busy, 1'b0);
        chk_int("six_high_cycles", highs, 24);

        // Illegal code: one-cycle err, nothing queued
        sym = 3'd6;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("ill_e0_err", err, 1'b1);
        chk("ill_e0_busy", busy, 1'b0);
        chk("ill_e0_signal", signal, 1'b0);
        tick();
        chk("ill_e1_err", err, 1'b0);
        chk("ill_e1_busy", busy, 1'b0);
        chk("ill_e1_signal", signal, 1'b0);

        // Reset in the middle of a DAH with a DIT queued behind it
        sym = 3'd2;
        sym_valid = 1'b1;
        tick();
        sym = 3'd1;
        tick();
        sym_valid = 1'b0;
        for (int e = 2; e <= 5; e++) tick();
        chk("rstmid_signal_before", signal, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_signal", signal, 1'b0);
        chk("rstmid_ready", sym_ready, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        highs = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (signal || busy) highs++;
        end
        chk_int("rstmid_quiet_cycles", highs, 0);

`ifdef MORSE_KEYER_SIDETONE_EN
        // Sidetone: tone high after edges 3-4 only
        sym = 3'd1;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        chk("tone_e0", tone, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("tone_e%0d", e), tone, (e == 3 || e == 4));
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
